// File: rtl/memory_access_pkg.sv
// Shared opcodes, bus size codes, FSM states and pipeline records for the MEM stage.
// Opcode helpers are used by memory_access and memory_access_load_align.
package memory_access_pkg;

    localparam logic [5:0] EXE_LB  = 6'b100000;
    localparam logic [5:0] EXE_LH  = 6'b100001;
    localparam logic [5:0] EXE_LW  = 6'b100011;
    localparam logic [5:0] EXE_LBU = 6'b100100;
    localparam logic [5:0] EXE_LHU = 6'b100101;
    localparam logic [5:0] EXE_SB  = 6'b101000;
    localparam logic [5:0] EXE_SH  = 6'b101001;
    localparam logic [5:0] EXE_SW  = 6'b101011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] inst;
        logic [4:0]  wreg;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc;
    } stage_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic [31:0] pc;
        logic [31:0] inst;
    } wb_t;

    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            EXE_LB, EXE_LBU, EXE_SB: return SIZE_BYTE;
            EXE_LH, EXE_LHU, EXE_SH: return SIZE_HALF;
            default:                 return SIZE_WORD;
        endcase
    endfunction

    // Narrow stores are replicated across every lane so the slave can pick any.
    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] d);
        case (op)
            EXE_SB:  return {4{d[7:0]}};
            EXE_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
    endfunction

    function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] a);
        case (size)
            SIZE_HALF: return {a[31:1], 1'b0};
            SIZE_WORD: return {a[31:2], 2'b00};
            default:   return a;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Picks the addressed byte/half lane out of a read word and sign/zero extends it.
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (opcode_i)
            EXE_LB:  data_o = {{24{byte_lane[7]}}, byte_lane};
            EXE_LBU: data_o = {24'h0, byte_lane};
            EXE_LH:  data_o = {{16{half_lane[15]}}, half_lane};
            EXE_LHU: data_o = {16'h0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: stage register, SRAM-like bus FSM (IDLE/REQ/WAIT) and writeback register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of masking the address.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              exe_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [31:0]       inst_in,
    input  logic [4:0]        write_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [DATA_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_result,
    output logic [4:0]        wb_write_reg,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_pc,
    output logic [31:0]       wb_inst,
    output logic [DATA_W-1:0] forward_data_mem,
    output logic              mem_adel,
    output logic              mem_ades
);

    state_e      state_q, state_d;
    stage_t      stage_q, stage_d;
    stage_t      txn_q, txn_d;
    wb_t         wb_q, wb_d;
    logic [31:0] load_data;
    logic [5:0]  txn_op;
    logic [1:0]  txn_size;
    logic        stage_mem;
    logic        stage_misal;
    logic        in_req;

    assign txn_op    = txn_q.inst[31:26];
    assign txn_size  = access_size(txn_op);
    assign stage_mem = stage_q.valid & (stage_q.mem_read | stage_q.mem_write);
    assign in_req    = (state_q == ST_REQ);

`ifdef MEM_ALIGN_CHECK_EN
    logic adel_q, adel_d, ades_q, ades_d;
    assign stage_misal = misaligned(access_size(stage_q.inst[31:26]), stage_q.alu[1:0]);
`else
    assign stage_misal = 1'b0;
`endif

    assign mem_stall = in_req | ((state_q == ST_WAIT) & ~data_data_ok);

    always_comb begin
        stage_d = stage_q;
        if (!mem_stall) begin
            stage_d.valid      = exe_valid;
            stage_d.alu        = alu_result;
            stage_d.wdata      = mem_data_in;
            stage_d.inst       = inst_in;
            stage_d.wreg       = write_reg_in;
            stage_d.reg_write  = exe_valid & reg_write_in;
            stage_d.mem_to_reg = mem_to_reg_in;
            stage_d.mem_read   = exe_valid & mem_read_in;
            stage_d.mem_write  = exe_valid & mem_write_in;
            stage_d.pc         = pc_in;
        end
    end

    // The memory op is copied out on entry to REQ so the stage register can take the next slot.
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (stage_mem && !stage_misal) begin
                    state_d = ST_REQ;
                    txn_d   = stage_q;
                end
            end
            ST_REQ:  if (data_addr_ok) state_d = ST_WAIT;
            ST_WAIT: if (data_data_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    memory_access_load_align u_align (
        .opcode_i (txn_op),
        .addr_i   (txn_q.alu[1:0]),
        .rdata_i  (data_rdata),
        .data_o   (load_data)
    );

    always_comb begin
        wb_d           = wb_q;
        wb_d.valid     = 1'b0;
        wb_d.reg_write = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        adel_d = 1'b0;
        ades_d = 1'b0;
`endif
        if ((state_q == ST_IDLE) && stage_q.valid && !stage_mem) begin
            wb_d.valid     = 1'b1;
            wb_d.result    = stage_q.alu;
            wb_d.write_reg = stage_q.wreg;
            wb_d.reg_write = stage_q.reg_write;
            wb_d.pc        = stage_q.pc;
            wb_d.inst      = stage_q.inst;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if ((state_q == ST_IDLE) && stage_mem && stage_misal) begin
            wb_d.valid     = 1'b1;
            wb_d.result    = stage_q.alu;
            wb_d.write_reg = stage_q.wreg;
            wb_d.pc        = stage_q.pc;
            wb_d.inst      = stage_q.inst;
            adel_d         = stage_q.mem_read;
            ades_d         = stage_q.mem_write;
        end
`endif
        else if ((state_q == ST_WAIT) && data_data_ok) begin
            wb_d.valid     = txn_q.valid;
            wb_d.result    = txn_q.mem_to_reg ? load_data : txn_q.alu;
            wb_d.write_reg = txn_q.wreg;
            wb_d.reg_write = txn_q.mem_read & txn_q.reg_write;
            wb_d.pc        = txn_q.pc;
            wb_d.inst      = txn_q.inst;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            txn_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            txn_q   <= txn_d;
            wb_q    <= wb_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
            ades_q <= ades_d;
        end
    end
    assign mem_adel  = adel_q;
    assign mem_ades  = ades_q;
    assign data_addr = in_req ? txn_q.alu : '0;
`else
    assign mem_adel  = 1'b0;
    assign mem_ades  = 1'b0;
    assign data_addr = in_req ? align_addr(txn_size, txn_q.alu) : '0;
`endif

    assign data_req   = in_req;
    assign data_wr    = in_req & txn_q.mem_write;
    assign data_size  = in_req ? txn_size : SIZE_BYTE;
    assign data_wdata = in_req ? store_lanes(txn_op, txn_q.wdata) : '0;

    assign wb_valid         = wb_q.valid;
    assign wb_result        = wb_q.result;
    assign wb_write_reg     = wb_q.write_reg;
    assign wb_reg_write     = wb_q.reg_write;
    assign wb_pc            = wb_q.pc;
    assign wb_inst          = wb_q.inst;
    assign forward_data_mem = wb_q.result;

endmodule

// File: tb/tb_memory_access.sv
// Table-driven bench for memory_access with a writeback scoreboard and bus responder.
module tb_memory_access;

    localparam logic [5:0] OP_ADDU = 6'b000000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic        clk, rstn, exe_valid;
    logic [31:0] alu_result, mem_data_in, inst_in, pc_in;
    logic [4:0]  write_reg_in;
    logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_stall, wb_valid, wb_reg_write;
    logic [31:0] wb_result, wb_pc, wb_inst, forward_data_mem;
    logic [4:0]  wb_write_reg;
    logic        mem_adel, mem_ades;

    memory_access #(.DATA_W(32)) dut (
        .clk(clk), .rstn(rstn), .exe_valid(exe_valid), .alu_result(alu_result),
        .mem_data_in(mem_data_in), .inst_in(inst_in), .write_reg_in(write_reg_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .pc_in(pc_in),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_write_reg(wb_write_reg),
        .wb_reg_write(wb_reg_write), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .forward_data_mem(forward_data_mem), .mem_adel(mem_adel), .mem_ades(mem_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr, wdata, rdata;
        logic        rd, wr, rw;
        logic [4:0]  wreg;
        int          aok, dok;
        logic        dok_in_req;
        logic        exp_req;
        logic [1:0]  exp_size;
        logic [31:0] exp_baddr, exp_wdata, exp_result;
        logic        exp_rw, chk_res, exp_adel, exp_ades;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        chk_res;
        logic [4:0]  wreg;
        logic        rw;
        logic [31:0] pc, inst;
        logic        adel, ades;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic rd, input logic wr, input logic rw, input logic [4:0] wreg,
                                input int aok, input int dok, input logic dinreq, input logic req,
                                input logic [1:0] sz, input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic [31:0] res, input logic erw, input logic chk,
                                input logic adel, input logic ades);
        vec_t v;
        v.name = nm; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd = rd; v.wr = wr; v.rw = rw; v.wreg = wreg; v.aok = aok; v.dok = dok;
        v.dok_in_req = dinreq; v.exp_req = req; v.exp_size = sz; v.exp_baddr = baddr;
        v.exp_wdata = bwdata; v.exp_result = res; v.exp_rw = erw; v.chk_res = chk;
        v.exp_adel = adel; v.exp_ades = ades;
        return v;
    endfunction

    // Writeback monitor: every retired entry must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (wb_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_res) begin
                        check("wb_result", wb_result, e.result);
                        check("fwd_data", forward_data_mem, e.result);
                    end
                    check("wb_write_reg", wb_write_reg, e.wreg);
                    check("wb_reg_write", wb_reg_write, e.rw);
                    check("wb_pc", wb_pc, e.pc);
                    check("wb_inst", wb_inst, e.inst);
                    check("adel_ades", {mem_adel, mem_ades}, {e.adel, e.ades});
                    $display("wb pc=%08h inst=%08h result=%08h reg=%0d we=%0b adel=%0b ades=%0b",
                             wb_pc, wb_inst, wb_result, wb_write_reg, wb_reg_write, mem_adel, mem_ades);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   req_n, wait_n, stalls;
        bit   in_wait, done, req_bad;
        @(negedge clk);
        exe_valid     = 1'b1;
        alu_result    = v.addr;
        mem_data_in   = v.wdata;
        inst_in       = {v.op, 26'(idx)};
        write_reg_in  = v.wreg;
        reg_write_in  = v.rw;
        mem_to_reg_in = v.rd;
        mem_read_in   = v.rd;
        mem_write_in  = v.wr;
        pc_in         = 32'h0040_0000 + 32'(idx * 4);
        data_rdata    = v.rdata;
        e.result = v.exp_result; e.chk_res = v.chk_res; e.wreg = v.wreg; e.rw = v.exp_rw;
        e.pc = pc_in; e.inst = inst_in; e.adel = v.exp_adel; e.ades = v.exp_ades;
        sb_q.push_back(e);
        @(negedge clk);
        exe_valid = 1'b0;
        #1;
        check({v.name, "_idle"}, {data_req, mem_stall}, 2'b00);
        if (!v.exp_req) begin
            @(negedge clk);
            #1;
            check({v.name, "_noreq"}, {data_req, wb_valid}, 2'b01);
            return;
        end
        req_n = 0; wait_n = 0; stalls = 0; in_wait = 0; done = 0; req_bad = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!in_wait) begin
                data_addr_ok = (req_n == v.aok);
                data_data_ok = v.dok_in_req;
            end else begin
                data_addr_ok = 1'b0;
                data_data_ok = (wait_n == v.dok);
            end
            #1;
            if (mem_stall === 1'b1) stalls++;
            if (!in_wait) begin
                if (data_req !== 1'b1) req_bad = 1;
                if (data_addr_ok) begin
                    check({v.name, "_size"}, data_size, v.exp_size);
                    check({v.name, "_addr"}, data_addr, v.exp_baddr);
                    check({v.name, "_wr"}, data_wr, v.wr);
                    check({v.name, "_wdata"}, data_wdata, v.exp_wdata);
                    in_wait = 1;
                end else begin
                    req_n++;
                end
            end else begin
                if (data_req !== 1'b0) req_bad = 1;
                if (data_data_ok) done = 1;
                else wait_n++;
            end
        end
        check({v.name, "_req_hold"}, req_bad, 1'b0);
        check({v.name, "_stall_cycles"}, stalls, v.aok + 1 + v.dok);
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        check({v.name, "_wb_latency"}, wb_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn = 1'b0; exe_valid = 1'b0; alu_result = '0; mem_data_in = '0; inst_in = '0;
        write_reg_in = '0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; pc_in = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

        vecs[0]  = mk("addu", OP_ADDU, 32'h5, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 32'h5, 1, 1, 0, 0);
        vecs[1]  = mk("lb_1003", OP_LB, 32'h1003, 0, 32'h80FF_FFFF, 1, 0, 1, 5'd4, 2, 1, 0, 1, 2'd0,
                      32'h1003, 0, 32'hFFFF_FF80, 1, 1, 0, 0);
        vecs[2]  = mk("lhu_1002", OP_LHU, 32'h1002, 0, 32'hBEEF_1234, 1, 0, 1, 5'd5, 0, 0, 0, 1, 2'd1,
                      32'h1002, 0, 32'h0000_BEEF, 1, 1, 0, 0);
        vecs[3]  = mk("lh_1002", OP_LH, 32'h1002, 0, 32'hBEEF_1234, 1, 0, 1, 5'd6, 1, 2, 0, 1, 2'd1,
                      32'h1002, 0, 32'hFFFF_BEEF, 1, 1, 0, 0);
        vecs[4]  = mk("sb_2001", OP_SB, 32'h2001, 32'h1234_56AB, 0, 0, 1, 1, 5'd7, 0, 0, 0, 1, 2'd0,
                      32'h2001, 32'hABAB_ABAB, 0, 0, 0, 0, 0);
        vecs[5]  = mk("sh_2002", OP_SH, 32'h2002, 32'hCAFE_5678, 0, 0, 1, 0, 5'd8, 3, 0, 1, 1, 2'd1,
                      32'h2002, 32'h5678_5678, 0, 0, 0, 0, 0);
        vecs[6]  = mk("sw_2004", OP_SW, 32'h2004, 32'h0102_0304, 0, 0, 1, 0, 5'd9, 1, 1, 0, 1, 2'd2,
                      32'h2004, 32'h0102_0304, 0, 0, 0, 0, 0);
        vecs[7]  = mk("lw_3000", OP_LW, 32'h3000, 0, 32'hDEAD_BEEF, 1, 0, 1, 5'd10, 0, 3, 1, 1, 2'd2,
                      32'h3000, 0, 32'hDEAD_BEEF, 1, 1, 0, 0);
        vecs[8]  = mk("lbu_1001", OP_LBU, 32'h1001, 0, 32'h1234_5678, 1, 0, 1, 5'd11, 0, 0, 0, 1, 2'd0,
                      32'h1001, 0, 32'h0000_0056, 1, 1, 0, 0);
        vecs[9]  = mk("lb_pos", OP_LB, 32'h1000, 0, 32'h1234_567F, 1, 0, 1, 5'd12, 0, 0, 0, 1, 2'd0,
                      32'h1000, 0, 32'h0000_007F, 1, 1, 0, 0);
        vecs[10] = mk("lh_lo", OP_LH, 32'h1000, 0, 32'h1234_8001, 1, 0, 1, 5'd13, 0, 1, 0, 1, 2'd1,
                      32'h1000, 0, 32'hFFFF_8001, 1, 1, 0, 0);
        vecs[11] = mk("lw_r0", OP_LW, 32'h1008, 0, 32'h55AA_55AA, 1, 0, 1, 5'd0, 1, 0, 0, 1, 2'd2,
                      32'h1008, 0, 32'h55AA_55AA, 1, 1, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        vecs[12] = mk("lw_1002", OP_LW, 32'h1002, 0, 32'h1122_3344, 1, 0, 1, 5'd14, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 1, 0);
        vecs[13] = mk("sh_2001", OP_SH, 32'h2001, 32'h0000_BEEF, 0, 0, 1, 0, 5'd15, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 1);
`else
        vecs[12] = mk("lw_1002", OP_LW, 32'h1002, 0, 32'h1122_3344, 1, 0, 1, 5'd14, 0, 0, 0, 1, 2'd2,
                      32'h1000, 0, 32'h1122_3344, 1, 1, 0, 0);
        vecs[13] = mk("sh_2001", OP_SH, 32'h2001, 32'h0000_BEEF, 0, 0, 1, 0, 5'd15, 0, 0, 0, 1, 2'd1,
                      32'h2000, 32'hBEEF_BEEF, 0, 0, 0, 0, 0);
`endif

        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", {data_req, data_wr, data_size, mem_stall, wb_valid, wb_reg_write, mem_adel, mem_ades}, '0);
        check("reset_wb", {wb_result, wb_pc}, '0);
        check("reset_bus", {data_addr, data_wdata}, '0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Bubble carrying load control bits must not touch the bus or writeback.
        @(negedge clk);
        exe_valid = 1'b0; alu_result = 32'h1000; inst_in = {OP_LB, 26'h0};
        mem_read_in = 1'b1; reg_write_in = 1'b1;
        @(negedge clk);
        #1;
        check("bubble_noreq", data_req, 1'b0);
        @(negedge clk);
        #1;
        check("bubble_nowb", {data_req, wb_valid}, 2'b00);

        // Reset while waiting for read data abandons the transaction.
        @(negedge clk);
        exe_valid = 1'b1; alu_result = 32'h4000; inst_in = {OP_LW, 26'h3}; write_reg_in = 5'd3;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        exe_valid = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b1;
        #1;
        check("rst_req_seen", data_req, 1'b1);
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        check("rst_wait_stall", {data_req, mem_stall}, 2'b01);
        rstn = 1'b0;
        #1;
        check("rst_async_clear", {data_req, mem_stall, wb_valid}, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        data_data_ok = 1'b1;
        #1;
        check("rst_dok_ignored", {data_req, mem_stall}, 2'b00);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        check("rst_no_wb", wb_valid, 1'b0);
        @(negedge clk);
        #1;
        check("rst_idle", {data_req, wb_valid}, 2'b00);

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
